// File: rtl/midi_message_parser.sv
// MIDI channel-message parser: rebuilds note and control-change events from the
// UART byte stream, honouring running status and ignoring real-time/system traffic.
module midi_message_parser #(
   parameter logic       CHANNEL_FILTER_EN = 1'b0,
   parameter logic [3:0] CHANNEL           = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din_valid,
   input  logic [7:0] din,
   output logic       note_valid,
   output logic       note_on,
   output logic [3:0] note_channel,
   output logic [6:0] note_num,
   output logic [6:0] note_velocity,
   output logic       cc_valid,
   output logic [3:0] cc_channel,
   output logic [6:0] cc_num,
   output logic [6:0] cc_value
);

   typedef enum logic [1:0] {
      NO_STATUS,
      WAIT_D1,
      WAIT_D2,
      SKIP
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] status_q, status_d;
   logic [6:0] d1_q, d1_d;

   logic       note_valid_d, note_on_d, cc_valid_d;
   logic [3:0] note_channel_d, cc_channel_d;
   logic [6:0] note_num_d, note_velocity_d, cc_num_d, cc_value_d;
   logic       chan_ok;

   assign chan_ok = !CHANNEL_FILTER_EN || (status_q[3:0] == CHANNEL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= NO_STATUS;
         status_q      <= '0;
         d1_q          <= '0;
         note_valid    <= 1'b0;
         note_on       <= 1'b0;
         note_channel  <= '0;
         note_num      <= '0;
         note_velocity <= '0;
         cc_valid      <= 1'b0;
         cc_channel    <= '0;
         cc_num        <= '0;
         cc_value      <= '0;
      end else begin
         state_q       <= state_d;
         status_q      <= status_d;
         d1_q          <= d1_d;
         note_valid    <= note_valid_d;
         note_on       <= note_on_d;
         note_channel  <= note_channel_d;
         note_num      <= note_num_d;
         note_velocity <= note_velocity_d;
         cc_valid      <= cc_valid_d;
         cc_channel    <= cc_channel_d;
         cc_num        <= cc_num_d;
         cc_value      <= cc_value_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      status_d        = status_q;
      d1_d            = d1_q;
      note_valid_d    = 1'b0;
      note_on_d       = note_on;
      note_channel_d  = note_channel;
      note_num_d      = note_num;
      note_velocity_d = note_velocity;
      cc_valid_d      = 1'b0;
      cc_channel_d    = cc_channel;
      cc_num_d        = cc_num;
      cc_value_d      = cc_value;

      if (din_valid) begin
         if (din[7:3] == 5'b11111) begin
            // real-time byte: transparent to the parser
         end else if (din[7:4] == 4'hF) begin
            state_d  = SKIP;
            status_d = '0;
         end else if (din[7]) begin
            state_d  = WAIT_D1;
            status_d = din;
         end else begin
            unique case (state_q)
               WAIT_D1: begin
                  d1_d = din[6:0];
                  // 0xCn/0xDn carry a single data byte, so the message closes here
                  state_d = (status_q[7:5] == 3'b110) ? WAIT_D1 : WAIT_D2;
               end
               WAIT_D2: begin
                  state_d = WAIT_D1;
                  if (chan_ok) begin
                     unique case (status_q[7:4])
                        4'h8, 4'h9: begin
                           note_valid_d    = 1'b1;
                           note_on_d       = status_q[4] && (din[6:0] != 7'd0);
                           note_channel_d  = status_q[3:0];
                           note_num_d      = d1_q;
                           note_velocity_d = note_on_d ? din[6:0] : 7'd0;
                        end
                        4'hB: begin
                           cc_valid_d   = 1'b1;
                           cc_channel_d = status_q[3:0];
                           cc_num_d     = d1_q;
                           cc_value_d   = din[6:0];
                        end
                        default: ;
                     endcase
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_midi_message_parser.sv
// Bench for midi_message_parser: an unfiltered and a channel-9-filtered instance
// share one byte stream and are checked against a message-level reference model.
module tb_midi_message_parser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din_valid = 1'b0;
   logic [7:0] din = '0;

   logic       nv[2], non[2], cv[2];
   logic [3:0] nch[2], cch[2];
   logic [6:0] nnum[2], nvel[2], cnum[2], cval[2];

   midi_message_parser #(.CHANNEL_FILTER_EN(1'b0), .CHANNEL(4'd9)) u_all (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
      .note_valid(nv[0]), .note_on(non[0]), .note_channel(nch[0]),
      .note_num(nnum[0]), .note_velocity(nvel[0]),
      .cc_valid(cv[0]), .cc_channel(cch[0]), .cc_num(cnum[0]), .cc_value(cval[0])
   );

   midi_message_parser #(.CHANNEL_FILTER_EN(1'b1), .CHANNEL(4'd9)) u_flt (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
      .note_valid(nv[1]), .note_on(non[1]), .note_channel(nch[1]),
      .note_num(nnum[1]), .note_velocity(nvel[1]),
      .cc_valid(cv[1]), .cc_channel(cch[1]), .cc_num(cnum[1]), .cc_value(cval[1])
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: running status plus a list of collected data bytes.
   logic       m_have;
   logic [7:0] m_status;
   logic [6:0] m_data[$];
   logic       e_nv[2], e_on[2], e_cv[2];
   logic [3:0] e_nch[2], e_cch[2];
   logic [6:0] e_num[2], e_vel[2], e_cnum[2], e_cval[2];

   function automatic void model_reset();
      m_have = 1'b0;
      m_status = '0;
      m_data.delete();
      for (int i = 0; i < 2; i++) begin
         e_nv[i] = 0; e_on[i] = 0; e_cv[i] = 0;
         e_nch[i] = 0; e_cch[i] = 0;
         e_num[i] = 0; e_vel[i] = 0; e_cnum[i] = 0; e_cval[i] = 0;
      end
   endfunction

   function automatic void model_emit();
      int kind = int'(m_status[7:4]);
      logic [3:0] ch = m_status[3:0];
      for (int i = 0; i < 2; i++) begin
         if (i == 1 && ch != 4'd9) continue;
         if (kind == 8 || kind == 9) begin
            e_nv[i]  = 1;
            e_on[i]  = (kind == 9) && (m_data[1] != 0);
            e_nch[i] = ch;
            e_num[i] = m_data[0];
            e_vel[i] = e_on[i] ? m_data[1] : 7'd0;
         end else if (kind == 11) begin
            e_cv[i]   = 1;
            e_cch[i]  = ch;
            e_cnum[i] = m_data[0];
            e_cval[i] = m_data[1];
         end
      end
   endfunction

   function automatic void model_step(logic r, logic v, logic [7:0] b);
      int len;
      for (int i = 0; i < 2; i++) begin
         e_nv[i] = 0;
         e_cv[i] = 0;
      end
      if (r) begin
         model_reset();
         return;
      end
      if (!v || b >= 8'hF8) return;
      if (b >= 8'hF0) begin
         m_have = 0;
         m_data.delete();
      end else if (b >= 8'h80) begin
         m_have = 1;
         m_status = b;
         m_data.delete();
      end else if (m_have) begin
         m_data.push_back(b[6:0]);
         len = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
         if (m_data.size() == len) begin
            if (len == 2) model_emit();
            m_data.delete();
         end
      end
   endfunction

   task automatic check_outputs(string tag);
      logic [38:0] act, exp;
      for (int i = 0; i < 2; i++) begin
         act = {nv[i], non[i], nch[i], nnum[i], nvel[i], cv[i], cch[i], cnum[i], cval[i]};
         exp = {e_nv[i], e_on[i], e_nch[i], e_num[i], e_vel[i],
                e_cv[i], e_cch[i], e_cnum[i], e_cval[i]};
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d outputs got=%h expected=%h", tag, i, act, exp);
         end
      end
   endtask

   // Drive one cycle of inputs, advance one clock, check both instances.
   task automatic step(logic r, logic v, logic [7:0] b, string tag);
      rst = r;
      din_valid = v;
      din = b;
      model_step(r, v, b);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] b;
      logic       en;
      logic       ec;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic r, logic v, logic [7:0] b, logic en, logic ec);
      vec_t t;
      t.r = r; t.v = v; t.b = b; t.en = en; t.ec = ec;
      tbl.push_back(t);
   endfunction

   initial begin
      model_reset();
      // expected pulse flags refer to the unfiltered instance
      add(0,1,8'h99,0,0); add(0,1,8'h24,0,0); add(0,1,8'h64,1,0);
      add(0,1,8'h26,0,0); add(0,1,8'h00,1,0);
      add(0,1,8'h80,0,0); add(0,1,8'h24,0,0); add(0,1,8'h50,1,0);
      add(0,0,8'h00,0,0);
      add(0,1,8'h90,0,0); add(0,1,8'h3C,0,0); add(0,1,8'hF8,0,0); add(0,1,8'h40,1,0);
      add(0,1,8'hFE,0,0);
      add(0,1,8'hF0,0,0); add(0,1,8'h7E,0,0); add(0,1,8'h01,0,0); add(0,1,8'hF7,0,0);
      add(0,1,8'h3C,0,0); add(0,1,8'h40,0,0);
      add(0,1,8'h90,0,0); add(0,1,8'h3C,0,0); add(0,1,8'h80,0,0);
      add(0,1,8'h3C,0,0); add(0,1,8'h00,1,0);
      add(0,1,8'hB2,0,0); add(0,1,8'h07,0,0); add(0,1,8'h7F,0,1);
      add(0,1,8'hC2,0,0); add(0,1,8'h05,0,0); add(0,1,8'h10,0,0); add(0,1,8'h20,0,0);
      add(0,1,8'h90,0,0); add(0,1,8'h24,0,0); add(0,1,8'h64,1,0);
      add(0,1,8'h99,0,0); add(0,1,8'h24,0,0); add(0,1,8'h64,1,0);
      add(0,0,8'h45,0,0);
      add(0,1,8'h99,0,0); add(0,1,8'h24,0,0); add(1,0,8'h00,0,0);
      add(0,1,8'h64,0,0); add(0,1,8'h26,0,0); add(0,1,8'h40,0,0);

      step(1, 0, 8'h00, "reset");
      step(1, 0, 8'h00, "reset");

      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].r, tbl[k].v, tbl[k].b, $sformatf("vec%0d", k));
         n_checks++;
         if ({nv[0], cv[0]} !== {tbl[k].en, tbl[k].ec}) begin
            n_fail++;
            $display("FAIL vec%0d pulses got=%b%b expected=%b%b",
                     k, nv[0], cv[0], tbl[k].en, tbl[k].ec);
         end
      end

      // Hand sequence: filtered instance ignores channel-0 CC but still tracks running status.
      step(0, 1, 8'hB0, "flt_cc"); step(0, 1, 8'h01, "flt_cc"); step(0, 1, 8'h02, "flt_cc");
      step(0, 1, 8'hB9, "flt_cc"); step(0, 1, 8'h03, "flt_cc"); step(0, 1, 8'h04, "flt_cc");
      step(0, 1, 8'h05, "flt_cc"); step(0, 1, 8'h06, "flt_cc");

      for (int k = 0; k < 4000; k++) begin
         int sel;
         logic [7:0] b;
         sel = $urandom_range(99);
         if (sel < 60)      b = 8'($urandom_range(127));
         else if (sel < 72) b = {4'($urandom_range(8, 11)), 4'($urandom_range(15))};
         else if (sel < 80) b = {4'($urandom_range(8, 14)), 4'($urandom_range(15))};
         else if (sel < 84) b = {4'($urandom_range(8, 11)), 4'd9};
         else if (sel < 93) b = 8'($urandom_range(8'hF8, 8'hFF));
         else               b = 8'($urandom_range(8'hF0, 8'hF7));
         step(($urandom_range(199) == 0), ($urandom_range(9) < 8), b, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
